// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, pc_src encodings
// and the control bundle carried through the EX/MEM register.
package ex_pkg;

  localparam int EX_DATA_W = 32;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_NOR = 5'b00100;
  localparam logic [4:0] ALU_SLL = 5'b00101;
  localparam logic [4:0] ALU_SRL = 5'b00110;
  localparam logic [4:0] ALU_SRA = 5'b00111;
  localparam logic [4:0] ALU_SLT = 5'b01000;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_JR  = 2'b01;

  // Memory-side control bits that travel with the result.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for the execute stage. Shifts act on rt by shamt; every
// other op acts on a/b. Unknown op codes give a zero result and flag illegal.
module alu_core
  import ex_pkg::*;
#(
  parameter int DATA_W = EX_DATA_W
) (
  input  logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] rt,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  // Operation select; add/sub wrap modulo 2^DATA_W with no overflow trap.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    unique case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLL: result = rt << shamt;
      ALU_SRL: result = rt >> shamt;
      ALU_SRA: result = $unsigned($signed(rt) >>> shamt);
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: runs the ALU on the decoded bundle, resolves jr redirects
// and holds the result in a one-entry EX/MEM register with valid/ready.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = EX_DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_dst,
  input  logic              alu_src,
  input  logic [1:0]        pc_src,
  input  logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [15:0]       imm,
  input  logic [4:0]        shamt,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        rd_addr,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [4:0]        out_dest,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  ex_count
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [DATA_W-1:0] out_store_q, out_store_d;
  logic [4:0]        out_dest_q, out_dest_d;
  mem_ctrl_t         out_ctrl_q, out_ctrl_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  ex_count_q, ex_count_d;

  logic              accept;
  logic              is_jr;
  logic [DATA_W-1:0] b_operand;
  logic [DATA_W-1:0] alu_result;
  logic              alu_illegal;

  // The slot is free when empty or when MEM takes the current entry this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  // Reserved pc_src codes behave as sequential.
  assign is_jr    = (pc_src == PC_JR);

  assign b_operand = alu_src ? {{(DATA_W-16){imm[15]}}, imm} : rt_val;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .alu_op  (alu_op),
    .a       (rs_val),
    .b       (b_operand),
    .rt      (rt_val),
    .shamt   (shamt),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  // Next-state for the EX/MEM entry, the one-cycle pulses and the counter.
  always_comb begin
    out_valid_d      = out_valid_q;
    out_result_d     = out_result_q;
    out_store_d      = out_store_q;
    out_dest_d       = out_dest_q;
    out_ctrl_d       = out_ctrl_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    illegal_d        = 1'b0;
    ex_count_d       = ex_count_q;

    if (accept) begin
      ex_count_d = ex_count_q + CNT_W'(1);
    end

    if (accept && is_jr) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = rs_val;
    end

    // jr never occupies the entry; a drain or flush still empties it.
    if (accept && !is_jr) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_store_d  = rt_val;
      out_dest_d   = reg_dst ? rt_addr : rd_addr;
      out_ctrl_d   = '{reg_write:  reg_write,
                       mem_to_reg: mem_to_reg,
                       mem_read:   mem_read,
                       mem_write:  mem_write};
      illegal_d    = alu_illegal;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Stage registers; reset empties the entry and clears every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_store_q      <= '0;
      out_dest_q       <= '0;
      out_ctrl_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      illegal_q        <= 1'b0;
      ex_count_q       <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_result_q     <= out_result_d;
      out_store_q      <= out_store_d;
      out_dest_q       <= out_dest_d;
      out_ctrl_q       <= out_ctrl_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      illegal_q        <= illegal_d;
      ex_count_q       <= ex_count_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_store_data = out_store_q;
  assign out_dest       = out_dest_q;
  assign out_reg_write  = out_ctrl_q.reg_write;
  assign out_mem_to_reg = out_ctrl_q.mem_to_reg;
  assign out_mem_read   = out_ctrl_q.mem_read;
  assign out_mem_write  = out_ctrl_q.mem_write;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign illegal_op     = illegal_q;
  assign ex_count       = ex_count_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage (CNT_W=4 so the counter wrap is reachable).
module tb_ex_stage;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        reg_write = 1'b0, mem_to_reg = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic        reg_dst = 1'b0, alu_src = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [4:0]  alu_op = 5'd0, shamt = 5'd0, rt_addr = 5'd0, rd_addr = 5'd0;
  logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
  logic [15:0] imm = 16'd0;

  logic        in_ready, out_valid, out_reg_write, out_mem_to_reg, out_mem_read, out_mem_write;
  logic        redirect_valid, illegal_op;
  logic [31:0] out_result, out_store_data, redirect_pc;
  logic [4:0]  out_dest;
  logic [CW-1:0] ex_count;

  ex_stage #(.DATA_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .reg_dst(reg_dst), .alu_src(alu_src), .pc_src(pc_src),
    .alu_op(alu_op), .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .shamt(shamt),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_result(out_result), .out_store_data(out_store_data),
    .out_dest(out_dest), .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .illegal_op(illegal_op), .ex_count(ex_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: what the EX/MEM register and pulses should hold.
  logic        m_valid, m_rw, m_m2r, m_mr, m_mw, m_redir, m_ill;
  logic [31:0] m_result, m_store, m_rpc;
  logic [4:0]  m_dest;
  int          m_cnt;

  task automatic m_reset();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_mr = 0; m_mw = 0; m_redir = 0; m_ill = 0;
    m_result = 0; m_store = 0; m_rpc = 0; m_dest = 0; m_cnt = 0;
  endtask

  // Behavioural ALU from the op table; returns {illegal, result}.
  function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] rt,
                                          input int sh);
    case (op)
      5'd0: return {1'b0, a + b};
      5'd1: return {1'b0, a - b};
      5'd2: return {1'b0, a & b};
      5'd3: return {1'b0, a | b};
      5'd4: return {1'b0, ~(a | b)};
      5'd5: return {1'b0, rt << sh};
      5'd6: return {1'b0, rt >> sh};
      5'd7: return {1'b0, rt[31] ? ~((~rt) >> sh) : (rt >> sh)};
      5'd8: return {1'b0, (int'(a) < int'(b)) ? 32'd1 : 32'd0};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic compare_all();
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("out_result", out_result, m_result);
    check("out_store_data", out_store_data, m_store);
    check("out_dest", {27'd0, out_dest}, {27'd0, m_dest});
    check("out_ctrl", {28'd0, out_reg_write, out_mem_to_reg, out_mem_read, out_mem_write},
          {28'd0, m_rw, m_m2r, m_mr, m_mw});
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir});
    check("redirect_pc", redirect_pc, m_rpc);
    check("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
    check("ex_count", {28'd0, ex_count}, m_cnt[31:0]);
  endtask

  // Called just after a falling edge with inputs already driven; advances one clock.
  task automatic cycle();
    logic rdy, acc, jr;
    logic [31:0] b;
    logic [32:0] r;
    #1;
    rdy = !m_valid || out_ready;
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    acc = in_valid && rdy && !flush;
    jr  = (pc_src == 2'b01);
    b   = alu_src ? {{16{imm[15]}}, imm} : rt_val;
    r   = ref_alu(alu_op, rs_val, b, rt_val, int'(shamt));
    @(posedge clk);
    #1;
    m_redir = acc && jr;
    m_rpc   = (acc && jr) ? rs_val : 32'd0;
    m_ill   = acc && !jr && r[32];
    if (acc) m_cnt = (m_cnt + 1) % (1 << CW);
    if (acc && !jr) begin
      m_valid = 1; m_result = r[31:0]; m_store = rt_val;
      m_dest = reg_dst ? rt_addr : rd_addr;
      m_rw = reg_write; m_m2r = mem_to_reg; m_mr = mem_read; m_mw = mem_write;
    end else if (flush || out_ready) begin
      m_valid = 0;
    end
    compare_all();
    $display("cycle t=%0t acc=%0d jr=%0d op=%0d out_valid=%0d result=0x%08h cnt=%0d",
             $time, acc, jr, alu_op, out_valid, out_result, ex_count);
    @(negedge clk);
  endtask

  task automatic put(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input logic src, input logic [15:0] im, input logic [4:0] sh,
                     input logic rdst, input logic [1:0] pcs);
    in_valid = 1; flush = 0; alu_op = op; rs_val = rs; rt_val = rt; alu_src = src;
    imm = im; shamt = sh; reg_dst = rdst; pc_src = pcs;
    rt_addr = 5'($urandom_range(0, 31)); rd_addr = 5'($urandom_range(0, 31));
    {reg_write, mem_to_reg, mem_read, mem_write} = 4'($urandom);
  endtask

  task automatic idle();
    in_valid = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; idle(); out_ready = 0;
    @(posedge clk); @(negedge clk);
    m_reset();
    compare_all();
    check("in_ready_rst", {31'd0, in_ready}, 32'd1);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] cnt_before;
    m_reset();
    @(negedge clk);
    do_reset();

    // add, addi with negative immediate, slt, sra
    out_ready = 1;
    put(5'd0, 32'd7, 32'd5, 0, 16'd0, 5'd0, 0, 2'b00); cycle();
    check("add_result", out_result, 32'd12);
    check("add_dest", {27'd0, out_dest}, {27'd0, rd_addr});
    put(5'd0, 32'd3, 32'd99, 1, 16'hFFFF, 5'd0, 1, 2'b00); cycle();
    check("addi_result", out_result, 32'd2);
    check("addi_dest", {27'd0, out_dest}, {27'd0, rt_addr});
    put(5'd8, 32'hFFFF_FFFF, 32'd1, 0, 16'd0, 5'd0, 0, 2'b00); cycle();
    check("slt_result", out_result, 32'd1);
    put(5'd7, 32'd0, 32'h8000_0000, 0, 16'd0, 5'd4, 0, 2'b00); cycle();
    check("sra_result", out_result, 32'hF800_0000);
    idle(); cycle();

    // stall: hold entry, second instruction waits, then captured on release
    do_reset();
    out_ready = 0;
    put(5'd3, 32'h0F0F_0000, 32'h0000_00F0, 0, 16'd0, 5'd0, 0, 2'b00); cycle();
    put(5'd1, 32'd100, 32'd1, 0, 16'd0, 5'd0, 0, 2'b00);
    repeat (3) cycle();
    check("stall_held", out_result, 32'h0F0F_00F0);
    out_ready = 1; cycle();
    check("stall_second", out_result, 32'd99);
    check("stall_count", {28'd0, ex_count}, 32'd2);
    idle(); cycle();

    // jr redirect: one-cycle pulse, entry stays empty
    put(5'd0, 32'h0040_0020, 32'd0, 0, 16'd0, 5'd0, 0, 2'b01); cycle();
    check("jr_pc", redirect_pc, 32'h0040_0020);
    check("jr_no_entry", {31'd0, out_valid}, 32'd0);
    idle(); cycle();

    // flush over a held entry, then an illegal op
    out_ready = 0;
    put(5'd2, 32'hFFFF_0000, 32'h00FF_FF00, 0, 16'd0, 5'd0, 0, 2'b00); cycle();
    cnt_before = {1'b0, ex_count};
    put(5'd0, 32'd1, 32'd1, 0, 16'd0, 5'd0, 0, 2'b01); flush = 1; cycle();
    check("flush_count", {28'd0, ex_count}, {27'd0, cnt_before});
    out_ready = 1;
    put(5'b11111, 32'd5, 32'd6, 0, 16'd0, 5'd0, 0, 2'b00); cycle();
    check("illegal_pulse", {31'd0, illegal_op}, 32'd1);
    idle(); cycle();

    // asynchronous reset while stalled
    out_ready = 0;
    put(5'd0, 32'd40, 32'd2, 0, 16'd0, 5'd0, 0, 2'b00); cycle();
    idle(); cycle();
    #2 rst_n = 0;
    #1 m_reset();
    compare_all();
    check("in_ready_async", {31'd0, in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // counter wrap: 15 accepts reach all-ones, the 16th wraps to 0
    out_ready = 1;
    for (int i = 0; i < 15; i++) begin
      put(5'd0, 32'(i), 32'd1, 0, 16'd0, 5'd0, 0, 2'b00); cycle();
    end
    check("cnt_ones", {28'd0, ex_count}, 32'd15);
    put(5'd0, 32'd0, 32'd0, 0, 16'd0, 5'd0, 0, 2'b00); cycle();
    check("cnt_wrap", {28'd0, ex_count}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 11));
      if (op > 5'd8) op = 5'($urandom_range(9, 31));
      put(op, $urandom, $urandom, 1'($urandom), 16'($urandom), 5'($urandom),
          1'($urandom), 2'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline; consumes the decoded control bundle produced by instruction decode plus register operands.
- Performs the ALU operation selected by alu_op.
- Resolves jr redirects.
- Holds the result in a one-entry EX/MEM pipeline register with a valid/ready handshake, stall and flush.

Parameters:
- DATA_W, 32, operand/result width
- CNT_W, 32, width of accepted-instruction counter

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- reg_write, mem_to_reg, mem_read, mem_write, reg_dst, alu_src  in  1 each  decoded control
- pc_src  in  2  00 sequential, 01 jump-register, 10/11 reserved
- alu_op  in  5  ALU operation code
- rs_val, rt_val  in  DATA_W  register operands
- imm  in  16  I-type immediate
- shamt  in  5  shift amount
- rt_addr, rd_addr  in  5  destination candidates
- flush  in  1  squash stage contents
- out_ready  in  1  MEM stage accepts
- out_valid  out  1  EX/MEM entry valid
- out_result  out  DATA_W  ALU result
- out_store_data  out  DATA_W  rt_val passthrough
- out_dest  out  5  destination register
- out_reg_write, out_mem_to_reg, out_mem_read, out_mem_write  out  1 each
- redirect_valid  out  1  one-cycle jr redirect pulse
- redirect_pc  out  DATA_W  jr target
- illegal_op  out  1  one-cycle pulse on unknown alu_op
- ex_count  out  CNT_W  accepted-instruction count

Behaviour:
- Reset (async, rst_n=0): all outputs 0, ex_count=0; in_ready is 1 after reset because it is a function of out_valid.
- in_ready = !out_valid || out_ready (combinational).
- Accept condition: in_valid && in_ready && !flush.
- B operand: alu_src=1 uses imm sign-extended to DATA_W; otherwise rt_val.
- alu_op codes:
  - 00000 add (A+B, modulo 2^DATA_W, no overflow trap; add and addu are identical)
  - 00001 sub (A-B)
  - 00010 and
  - 00011 or
  - 00100 nor
  - 00101 sll
  - 00110 srl
  - 00111 sra
  - 01000 slt (signed, result 0 or 1)
- Shifts operate on rt_val by shamt; A and B are ignored.
- Any other alu_op: result 0, illegal_op pulses the cycle after acceptance, and the entry is still written with its control bits.
- out_dest = reg_dst ? rt_addr : rd_addr (0 selects rd, 1 selects rt).
- pc_src=01 (jr):
  - Not written to EX/MEM; out_valid is unaffected by it.
  - redirect_valid=1 and redirect_pc=rs_val for exactly one cycle following acceptance.
- pc_src 10/11: treated as 00.
- Latency: accepted at edge N, then visible on out_* during cycle N+1.
- Stall: out_valid && !out_ready holds all out_* stable; in_ready=0.
- Drain: out_valid && out_ready with no accept clears out_valid next cycle.
- Simultaneous drain+accept: the new entry replaces the old with no bubble.
- flush=1:
  - out_valid cleared next cycle, regardless of out_ready.
  - No capture, no redirect, no illegal_op; the input is dropped.
  - in_ready still follows its formula.
- ex_count increments on every accept, including jr and illegal ops, and wraps at 2^CNT_W to 0.
- Reset asserted mid-stall: entry discarded, all outputs cleared immediately.

Decomposition:
- Package ex_pkg: ALU op localparams (ALU_ADD..ALU_SLT), pc_src encodings (PC_SEQ, PC_JR), DATA_W default.
- Sub-module alu_core: combinational; inputs alu_op/a/b/rt/shamt; outputs result and illegal. ex_stage owns all registers.

Test Plan:
- add: rs=7, rt=5, alu_src=0, alu_op=00000, out_ready=1 -> next cycle out_valid=1, out_result=12, out_dest=rd_addr.
- addi-style: alu_src=1, imm=16'hFFFF, rs=3, reg_dst=1 -> out_result=2, out_dest=rt_addr. Also slt with rs=-1, rt=1 -> 1. Also sra with rt=0x80000000, shamt=4 -> 0xF8000000.
- Stall: out_ready=0 with entry held, then present a second instruction -> in_ready=0, out_* unchanged 3 cycles; raise out_ready -> second captured the following edge, ex_count=2.
- jr: pc_src=01, rs=0x00400020 -> redirect_valid high one cycle with redirect_pc=0x00400020; out_valid stays 0.
- Flush with in_valid=1 and a held entry -> out_valid=0 next cycle, no redirect, ex_count unchanged. Then alu_op=5'b11111 -> out_result=0, illegal_op one-cycle pulse.
- Assert rst_n=0 asynchronously mid-stall -> all outputs 0 before the next clock edge; ex_count wraps from all-ones to 0 on the next accept after preload (CNT_W=4 build).
